// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: FSM state codes, vector count and golden gate model shared by the gate BIST.
package gate_bist_pkg;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRIVE  = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;
    localparam int NUM_VEC = 4;

    function automatic logic [2:0] expected(input logic x, input logic y);
        return {x & y, x | y, ~x};
    endfunction
endpackage

// File: rtl/gate_bist_seq_if.sv
// gate_bist_seq_if: stimulus, gate responses and result signals of the gate BIST.
interface gate_bist_seq_if #(parameter int ERR_W = 4);
    logic             start;
    logic             x;
    logic             y;
    logic             and_in;
    logic             or_in;
    logic             not_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       fail_vec;
    logic [2:0]       fail_mask;

    modport master (output start, and_in, or_in, not_in,
                    input  x, y, busy, done, pass, err_count, fail_vec, fail_mask);
    modport slave  (input  start, and_in, or_in, not_in,
                    output x, y, busy, done, pass, err_count, fail_vec, fail_mask);
endinterface

// File: rtl/gate_bist_chk.sv
// gate_bist_chk: compares returned gate outputs with the golden model and counts mismatched bits.
module gate_bist_chk
    import gate_bist_pkg::*;
(
    input  logic [1:0] xy,
    input  logic       and_in,
    input  logic       or_in,
    input  logic       not_in,
    output logic [2:0] mismatch,
    output logic [1:0] pop
);
    assign mismatch = {and_in, or_in, not_in} ^ expected(xy[1], xy[0]);
    assign pop = {1'b0, mismatch[0]} + {1'b0, mismatch[1]} + {1'b0, mismatch[2]};
endmodule

// File: rtl/gate_bist_seq.sv
// gate_bist_seq: walks {x,y} through all four combinations, samples the gate outputs after a
// settle time and accumulates a saturating mismatch count plus the first failing vector.
module gate_bist_seq
    import gate_bist_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int ERR_W       = 4
) (
    input logic           clk,
    input logic           rst,
    gate_bist_seq_if.slave bus
);
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;

    logic [1:0]       state;
    logic [HW-1:0]    hold;
    logic [1:0]       idx;
    logic [2:0]       mismatch;
    logic [1:0]       pop;
    logic [ERR_W+1:0] sum;
    logic [ERR_W-1:0] err_next;
    logic [ERR_W-1:0] err;
    logic [1:0]       fvec;
    logic [2:0]       fmask;
    logic             pass_r;

    gate_bist_chk u_chk (
        .xy      (idx),
        .and_in  (bus.and_in),
        .or_in   (bus.or_in),
        .not_in  (bus.not_in),
        .mismatch(mismatch),
        .pop     (pop)
    );

    // Two guard bits keep the carry visible so the counter can clamp at all-ones.
    assign sum      = {2'b00, err} + {{ERR_W{1'b0}}, pop};
    assign err_next = |sum[ERR_W+1:ERR_W] ? '1 : sum[ERR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            hold   <= '0;
            idx    <= '0;
            err    <= '0;
            fvec   <= '0;
            fmask  <= '0;
            pass_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state  <= DRIVE;
                    hold   <= '0;
                    idx    <= '0;
                    err    <= '0;
                    fvec   <= '0;
                    fmask  <= '0;
                    pass_r <= 1'b0;
                end
                DRIVE: begin
                    state <= hold == HW'(HOLD_CYCLES - 1) ? SAMPLE : DRIVE;
                    hold  <= hold == HW'(HOLD_CYCLES - 1) ? '0 : hold + 1'b1;
                end
                SAMPLE: begin
                    err    <= err_next;
                    fvec   <= (fmask == 3'b000 && mismatch != 3'b000) ? idx : fvec;
                    fmask  <= (fmask == 3'b000) ? mismatch : fmask;
                    pass_r <= idx == 2'(NUM_VEC - 1) && err_next == '0;
                    state  <= idx == 2'(NUM_VEC - 1) ? DONE : DRIVE;
                    idx    <= idx + 2'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // idx wraps to 0 on leaving the last SAMPLE, so {x,y} is already 00 in DONE and IDLE.
    assign bus.x         = idx[1];
    assign bus.y         = idx[0];
    assign bus.busy      = state == DRIVE || state == SAMPLE;
    assign bus.done      = state == DONE;
    assign bus.pass      = pass_r;
    assign bus.err_count = err;
    assign bus.fail_vec  = fvec;
    assign bus.fail_mask = fmask;
endmodule

// File: tb/tb_gate_bist_seq.sv
// tb_gate_bist_seq: directed checks of the gate BIST with modelled good and faulty gates.
module tb_gate_bist_seq;
    logic clk = 1'b0;
    logic rst;
    logic tie0, nf, inv, glitch;
    int checks = 0, errors = 0;
    int done_at, done3_at, done_cnt;
    logic [7:0] seq;
    logic busy1;

    always #5 clk = ~clk;

    gate_bist_seq_if #(.ERR_W(4)) b1 ();
    gate_bist_seq_if #(.ERR_W(2)) b2 ();
    gate_bist_seq_if #(.ERR_W(4)) b3 ();

    gate_bist_seq #(.HOLD_CYCLES(2), .ERR_W(4)) dut  (.clk(clk), .rst(rst), .bus(b1));
    gate_bist_seq #(.HOLD_CYCLES(2), .ERR_W(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    gate_bist_seq #(.HOLD_CYCLES(1), .ERR_W(4)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    assign b1.and_in = inv ? ~(b1.x & b1.y) : (tie0 ? 1'b0 : (b1.x & b1.y));
    assign b1.or_in  = inv ? ~(b1.x | b1.y) : (b1.x | b1.y);
    assign b1.not_in = (inv || nf || glitch) ? b1.x : ~b1.x;
    assign b2.and_in = ~(b2.x & b2.y);
    assign b2.or_in  = ~(b2.x | b2.y);
    assign b2.not_in = b2.x;
    assign b3.and_in = b3.x & b3.y;
    assign b3.or_in  = b3.x | b3.y;
    assign b3.not_in = ~b3.x;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic all, input logic rep, input logic gl);
        @(negedge clk);
        b1.start = 1'b1; b2.start = all; b3.start = all;
        @(posedge clk); #1;
        b1.start = 1'b0; b2.start = 1'b0; b3.start = 1'b0; glitch = gl;
        done_at = 0; done3_at = 0; done_cnt = 0; seq = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            glitch = 1'b0;
            if (n == 1) busy1 = b1.busy;
            if (b1.done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
            if (b3.done && done3_at == 0) done3_at = n;
            if (n % 3 == 1 && n < 12) seq[7 - 2 * (n / 3) -: 2] = {b1.x, b1.y};
            b1.start = rep && (n == 2 || n == 11);
        end
    endtask

    initial begin
        rst = 1'b1; tie0 = 0; nf = 0; inv = 0; glitch = 0;
        b1.start = 0; b2.start = 0; b3.start = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", b1.busy, 0);
        chk("rst_done", b1.done, 0);
        chk("rst_pass", b1.pass, 0);
        chk("rst_err", b1.err_count, 0);
        chk("rst_xy", {b1.x, b1.y}, 0);
        chk("rst_fail", {b1.fail_vec, b1.fail_mask}, 0);
        @(negedge clk) rst = 1'b0;

        // good gates on all three instances
        run(1, 0, 0);
        chk("good_done_at", done_at, 12);
        chk("good_busy", busy1, 1);
        chk("good_seq", seq, 8'b00_01_10_11);
        chk("good_pass", b1.pass, 1);
        chk("good_err", b1.err_count, 0);
        chk("good_fail", {b1.fail_vec, b1.fail_mask}, 0);
        chk("idle_xy", {b1.x, b1.y}, 0);
        chk("idle_busy", b1.busy, 0);
        chk("h1_done_at", done3_at, 8);
        chk("h1_pass", b3.pass, 1);
        chk("sat_err", b2.err_count, 3);
        chk("sat_mask", b2.fail_mask, 3'b111);
        chk("sat_vec", b2.fail_vec, 0);
        chk("sat_pass", b2.pass, 0);

        tie0 = 1;
        run(0, 0, 0);
        chk("and0_err", b1.err_count, 1);
        chk("and0_vec", b1.fail_vec, 2'b11);
        chk("and0_mask", b1.fail_mask, 3'b100);
        chk("and0_pass", b1.pass, 0);
        tie0 = 0;

        nf = 1;
        run(0, 0, 0);
        chk("not_err", b1.err_count, 4);
        chk("not_vec", b1.fail_vec, 2'b00);
        chk("not_mask", b1.fail_mask, 3'b001);
        nf = 0;

        inv = 1;
        run(0, 0, 0);
        chk("inv_err", b1.err_count, 12);
        chk("inv_mask", b1.fail_mask, 3'b111);
        chk("inv_vec", b1.fail_vec, 0);
        inv = 0;

        run(0, 0, 1);
        chk("glitch_pass", b1.pass, 1);
        chk("glitch_err", b1.err_count, 0);

        tie0 = 1;
        run(0, 1, 0);
        chk("rep_done_at", done_at, 12);
        chk("rep_done_cnt", done_cnt, 1);
        chk("rep_err", b1.err_count, 1);
        chk("rep_vec", b1.fail_vec, 2'b11);
        chk("rep_busy", b1.busy, 0);
        tie0 = 0;

        // second run with faults, interrupted by reset after the first vector has been scored
        inv = 1;
        @(negedge clk) b1.start = 1'b1;
        @(posedge clk); #1 b1.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_err", b1.err_count, 3);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("mr_busy", b1.busy, 0);
        chk("mr_xy", {b1.x, b1.y}, 0);
        chk("mr_err", b1.err_count, 0);
        chk("mr_fail", {b1.fail_vec, b1.fail_mask}, 0);
        chk("mr_pass", b1.pass, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        done_cnt = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (b1.done || b1.busy) done_cnt++;
        end
        chk("mr_no_done", done_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
